// File: rtl/atomicity_pkg.sv
// Shared definitions for the multi-region atomicity monitor: FSM state encoding,
// violation cause codes, region count limit and small helpers.
package atomicity_pkg;

    localparam int NUM_REGIONS_MAX = 4;

    typedef enum logic [2:0] {
        ST_NOT_RC  = 3'd0,
        ST_FST_RC  = 3'd1,
        ST_MID_RC  = 3'd2,
        ST_LAST_RC = 3'd3,
        ST_KILL    = 3'd4
    } rc_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ENTRY   = 2'd1,
        CAUSE_EXIT    = 2'd2,
        CAUSE_PREEMPT = 2'd3
    } cause_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/multi_region_atomicity_region_decode.sv
// Address decode for one protected region: first/mid/last/inside flags for the current pc.
module region_decode
    import atomicity_pkg::*;
#(
    parameter logic [15:0] BASE = 16'hE000,
    parameter logic [15:0] SIZE = 16'h1000
) (
    input  logic [15:0] pc,
    output logic        is_first,
    output logic        is_mid,
    output logic        is_last,
    output logic        is_inside
);

    // Last instruction slot is the final halfword of the region.
    localparam logic [15:0] LAST = BASE + SIZE - 16'd2;

    assign is_first  = (pc == BASE);
    assign is_last   = (pc == LAST);
    assign is_mid    = (pc > BASE) && (pc < LAST);
    assign is_inside = (pc >= BASE) && (pc <= LAST);

endmodule

// File: rtl/multi_region_atomicity.sv
// Enforces atomic execution of up to four code regions: entry only at the first
// instruction, exit only from the last, no irq/DMA inside; violations hold MCU reset.
module multi_region_atomicity
    import atomicity_pkg::*;
#(
    parameter int                          NUM_REGIONS   = 2,
    parameter logic [16*NUM_REGIONS-1:0]   REGION_BASE   = {16'hA000, 16'hE000},
    parameter logic [16*NUM_REGIONS-1:0]   REGION_SIZE   = {16'h0100, 16'h1000},
    parameter logic [15:0]                 RESET_HANDLER = 16'hFFFE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] pc,
    input  logic        pc_en,
    input  logic        irq,
    input  logic        dma_en,
    output logic        reset,
    output logic [1:0]  cause,
    output logic [1:0]  active_region,
    output logic [7:0]  viol_count
);

    function automatic bit cfg_ok();
        int bi;
        int si;
        int bj;
        int sj;
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            bi = int'(REGION_BASE[16*i +: 16]);
            si = int'(REGION_SIZE[16*i +: 16]);
            if ((bi % 2) != 0 || (si % 2) != 0 || si < 4 || (bi + si) > 65536) begin
                ok = 1'b0;
            end
            for (int j = i + 1; j < NUM_REGIONS; j++) begin
                bj = int'(REGION_BASE[16*j +: 16]);
                sj = int'(REGION_SIZE[16*j +: 16]);
                if (bi < bj + sj && bj < bi + si) begin
                    ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

    if (NUM_REGIONS < 1 || NUM_REGIONS > NUM_REGIONS_MAX) begin : g_count_error
        $fatal(1, "multi_region_atomicity: NUM_REGIONS out of range 1..4");
    end else if (!cfg_ok()) begin : g_cfg_error
        $fatal(1, "multi_region_atomicity: odd, undersized, wrapping or overlapping region");
    end

    logic [NUM_REGIONS_MAX-1:0] first_v_s;
    logic [NUM_REGIONS_MAX-1:0] mid_v_s;
    logic [NUM_REGIONS_MAX-1:0] last_v_s;
    logic [NUM_REGIONS_MAX-1:0] inside_v_s;

    // Unused region slots are tied off so cur can always index a full-width vector.
    for (genvar g = 0; g < NUM_REGIONS_MAX; g++) begin : g_region
        if (g < NUM_REGIONS) begin : g_inst
            region_decode #(
                .BASE (REGION_BASE[16*g +: 16]),
                .SIZE (REGION_SIZE[16*g +: 16])
            ) u_region_decode (
                .pc        (pc),
                .is_first  (first_v_s[g]),
                .is_mid    (mid_v_s[g]),
                .is_last   (last_v_s[g]),
                .is_inside (inside_v_s[g])
            );
        end else begin : g_tie
            assign first_v_s[g]  = 1'b0;
            assign mid_v_s[g]    = 1'b0;
            assign last_v_s[g]   = 1'b0;
            assign inside_v_s[g] = 1'b0;
        end
    end

    rc_state_e   state_r;
    cause_e      cause_r;
    logic [1:0]  cur_r;
    logic        reset_r;
    logic [1:0]  active_r;
    logic [7:0]  count_r;

    logic        first_any_s;
    logic        inside_any_s;
    logic [1:0]  first_idx_s;
    rc_state_e   nxt_state_s;
    cause_e      nxt_cause_s;
    logic [1:0]  nxt_cur_s;

    // Which region (if any) starts at the current pc.
    always_comb begin
        first_idx_s  = 2'd0;
        first_any_s  = |first_v_s;
        inside_any_s = |inside_v_s;
        for (int k = NUM_REGIONS_MAX - 1; k >= 0; k--) begin
            first_idx_s = first_v_s[k] ? 2'(k) : first_idx_s;
        end
    end

    // Next-state decision for the atomicity FSM.
    always_comb begin
        nxt_state_s = state_r;
        nxt_cause_s = cause_r;
        nxt_cur_s   = cur_r;
        case (state_r)
            ST_NOT_RC: begin
                if (first_any_s) begin
                    nxt_state_s = ST_FST_RC;
                    nxt_cur_s   = first_idx_s;
                end else if (inside_any_s) begin
                    nxt_state_s = ST_KILL;
                    nxt_cause_s = CAUSE_ENTRY;
                end else begin
                    nxt_state_s = ST_NOT_RC;
                end
            end
            ST_FST_RC: begin
                if (irq || dma_en) begin
                    nxt_state_s = ST_KILL;
                    nxt_cause_s = CAUSE_PREEMPT;
                end else if (first_v_s[cur_r]) begin
                    nxt_state_s = ST_FST_RC;
                end else if (mid_v_s[cur_r]) begin
                    nxt_state_s = ST_MID_RC;
                end else begin
                    nxt_state_s = ST_KILL;
                    nxt_cause_s = CAUSE_EXIT;
                end
            end
            ST_MID_RC: begin
                if (irq || dma_en) begin
                    nxt_state_s = ST_KILL;
                    nxt_cause_s = CAUSE_PREEMPT;
                end else if (mid_v_s[cur_r]) begin
                    nxt_state_s = ST_MID_RC;
                end else if (last_v_s[cur_r]) begin
                    nxt_state_s = ST_LAST_RC;
                end else begin
                    nxt_state_s = ST_KILL;
                    nxt_cause_s = CAUSE_EXIT;
                end
            end
            ST_LAST_RC: begin
                if (last_v_s[cur_r]) begin
                    nxt_state_s = ST_LAST_RC;
                end else if (!inside_any_s) begin
                    nxt_state_s = ST_NOT_RC;
                end else if (first_any_s && (first_idx_s != cur_r)) begin
                    nxt_state_s = ST_FST_RC;
                    nxt_cur_s   = first_idx_s;
                end else begin
                    nxt_state_s = ST_KILL;
                    nxt_cause_s = CAUSE_EXIT;
                end
            end
            ST_KILL: begin
                if (pc == RESET_HANDLER) begin
                    nxt_state_s = ST_NOT_RC;
                    nxt_cause_s = CAUSE_NONE;
                end else begin
                    nxt_state_s = ST_KILL;
                end
            end
            default: begin
                nxt_state_s = ST_KILL;
                nxt_cause_s = cause_r;
            end
        endcase
    end

    // State and registered outputs; everything freezes while pc is not valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_KILL;
            cause_r  <= CAUSE_NONE;
            cur_r    <= 2'd0;
            reset_r  <= 1'b1;
            active_r <= 2'd0;
            count_r  <= 8'd0;
        end else if (pc_en) begin
            state_r  <= nxt_state_s;
            cause_r  <= nxt_cause_s;
            cur_r    <= nxt_cur_s;
            reset_r  <= (nxt_state_s == ST_KILL);
            active_r <= (nxt_state_s == ST_FST_RC || nxt_state_s == ST_MID_RC ||
                         nxt_state_s == ST_LAST_RC) ? nxt_cur_s : 2'd0;
            if (nxt_state_s == ST_KILL && state_r != ST_KILL) begin
                count_r <= sat_inc8(count_r);
            end
        end
    end

    assign reset         = reset_r;
    assign cause         = cause_r;
    assign active_region = active_r;
    assign viol_count    = count_r;

endmodule

// File: doc/multi_region_atomicity.md
MULTI_REGION_ATOMICITY -- requirements
Module: multi_region_atomicity

Interface
REQ-001 SHALL take parameter NUM_REGIONS, default 2: number of protected code regions, legal range 1..4.
REQ-002 SHALL take parameter REGION_BASE, default {16'hA000,16'hE000}: packed 16*NUM_REGIONS vector; region i base address is bits [16*i+:16].
REQ-003 SHALL take parameter REGION_SIZE, default {16'h0100,16'h1000}: packed 16*NUM_REGIONS vector of region byte sizes, same packing as REGION_BASE.
REQ-004 SHALL take parameter RESET_HANDLER, default 16'hFFFE: the only PC value that releases the KILL state.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port pc, input, 16 bits: current program counter.
REQ-008 SHALL have port pc_en, input, 1 bit: pc valid this cycle; when low, all registers hold.
REQ-009 SHALL have port irq, input, 1 bit: interrupt being serviced this cycle.
REQ-010 SHALL have port dma_en, input, 1 bit: DMA bus access this cycle.
REQ-011 SHALL have port reset, output, 1 bit: registered MCU reset request, high while in KILL.
REQ-012 SHALL have port cause, output, 2 bits: violation cause, 0 none, 1 illegal entry, 2 illegal exit or jump, 3 irq/DMA during region.
REQ-013 SHALL have port active_region, output, 2 bits: index of region currently executing; 0 when none.
REQ-014 SHALL have port viol_count, output, 8 bits: saturating count of KILL entries.

Function
REQ-015 SHALL, per region i, define first=base_i, last=base_i+size_i-2, mid = first<pc<last, inside = first<=pc<=last, using 16-bit unsigned compares.
REQ-016 SHALL implement states NOT_RC, FST_RC, MID_RC, LAST_RC, KILL, plus a current-region register cur.
REQ-017 SHALL, in NOT_RC: pc outside all regions keeps NOT_RC; pc==first of region j goes to FST_RC with cur=j; pc elsewhere inside any region goes to KILL with cause 1.
REQ-018 SHALL, in FST_RC: pc==first(cur) stays; mid(cur) goes to MID_RC; any other pc goes to KILL with cause 2.
REQ-019 SHALL, in MID_RC: mid(cur) stays; pc==last(cur) goes to LAST_RC; any other pc goes to KILL with cause 2.
REQ-020 SHALL, in LAST_RC: pc==last(cur) stays; pc outside all regions goes to NOT_RC; pc==first of region j!=cur goes to FST_RC with cur=j (back-to-back chaining); any other pc goes to KILL with cause 2.
REQ-021 SHALL, in FST_RC or MID_RC, go to KILL with cause 3 when irq or dma_en is high, overriding any pc-based transition; LAST_RC is not subject to this rule.
REQ-022 SHALL, in KILL, go to NOT_RC only when pc==RESET_HANDLER; otherwise hold; cause clears to 0 on that exit.
REQ-023 SHALL register reset so that it is high exactly in cycles where state==KILL, i.e. asserted one cycle after the violating pc and deasserted one cycle after pc==RESET_HANDLER.
REQ-024 SHALL, when pc_en is low, hold state, cur, cause, reset and viol_count, ignoring irq and dma_en.
REQ-025 SHALL increment viol_count by one on each transition into KILL from a non-KILL state, saturating at 8'hFF.
REQ-026 SHALL drive active_region=cur in FST_RC, MID_RC and LAST_RC, and 0 otherwise.

Reset
REQ-027 SHALL, on reset_n low, asynchronously set state=KILL, reset=1, cause=0, cur=0, active_region=0 and viol_count=0.
REQ-028 SHALL, after reset_n release, leave KILL only via pc==RESET_HANDLER with pc_en high.

Structure
REQ-029 SHALL place the state encoding, the cause codes and the NUM_REGIONS maximum in a shared package atomicity_pkg.
REQ-030 SHALL use one sub-module, region_decode, instantiated NUM_REGIONS times, producing is_first/is_mid/is_last/is_inside per region.
REQ-031 SHALL fail elaboration on odd base or size, size<4, base+size>2^16, or overlapping regions.

Verification
REQ-032 SHALL cover: reset_n release, pc=FFFE with pc_en=1 -> next cycle reset=0, state NOT_RC, viol_count=0.
REQ-033 SHALL cover: pc E000, E002, EFFE, 4000 -> no reset at any point, active_region=0 after 4000.
REQ-034 SHALL cover: pc from NOT_RC to E010 -> reset=1 the next cycle, cause=1, viol_count=1.
REQ-035 SHALL cover: pc E000, E002 with irq=1 on E002 -> reset=1 the next cycle, cause=3.
REQ-036 SHALL cover: pc E000, E002, EFFE, A000, A002, A0FE, 4000 -> no reset; active_region=1 while pc is in A000..A0FE.
REQ-037 SHALL cover: pc_en=0 with pc=E010 for 3 cycles in NOT_RC -> no change to any output; 256 violations -> viol_count saturates at FF.
